// File: rtl/seg_scan_mux_if.sv
// Segment-scan bus bundle: frame inputs from the digit encoders, multiplexed drive to the display.
// SEG_DIM_EN adds the 2-bit bright input.
interface seg_scan_mux_if #(
  parameter int N_DIGITS = 6
);
  logic [8*N_DIGITS-1:0] seg_in;
  logic [N_DIGITS-1:0]   digit_en;
`ifdef SEG_DIM_EN
  logic [1:0]            bright;
`endif
  logic [7:0]            seg_com;
  logic [N_DIGITS-1:0]   seg_dig;
  logic [2:0]            scan_idx;
  logic                  frame_tick;

`ifdef SEG_DIM_EN
  modport master (output seg_in, digit_en, bright,
                  input  seg_com, seg_dig, scan_idx, frame_tick);
  modport slave  (input  seg_in, digit_en, bright,
                  output seg_com, seg_dig, scan_idx, frame_tick);
`else
  modport master (output seg_in, digit_en,
                  input  seg_com, seg_dig, scan_idx, frame_tick);
  modport slave  (input  seg_in, digit_en,
                  output seg_com, seg_dig, scan_idx, frame_tick);
`endif
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment driver with blanking gap and frame-latched codes; SEG_DIM_EN adds PWM dimming.
// All outputs registered from pre-edge counters (1-cycle latency); free-running, no backpressure.
module seg_scan_mux #(
  parameter int N_DIGITS    = 6,
  parameter int SCAN_DIV    = 1000,
  parameter int BLANK_CYC   = 16,
  parameter bit DIG_ACT_LOW = 1'b1
) (
  input  logic          clk_in,
  input  logic          rst,
  seg_scan_mux_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_V  = CW'(BLANK_CYC);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);
  // XOR mask that turns the active-high select into the pin polarity; also the idle pattern.
  localparam logic [N_DIGITS-1:0] DIG_IDLE = DIG_ACT_LOW ? '1 : '0;

  logic [CW-1:0]         pre_cnt;
  logic [IW-1:0]         idx;
  logic [8*N_DIGITS-1:0] shadow;

  logic                  slot_end;
  logic                  frame_start;
  logic                  frame_end;
  logic                  drive;
  logic [8*N_DIGITS-1:0] frame_data;
  logic [7:0]            seg_nxt;
  logic [N_DIGITS-1:0]   dig_on;
`ifdef SEG_DIM_EN
  logic [31:0]           k;
  logic [31:0]           win;
`endif

  always_comb begin
    slot_end    = (pre_cnt == LAST_CNT);
    frame_start = (pre_cnt == '0) && (idx == '0);
    frame_end   = slot_end && (idx == LAST_IDX);
    // On the load edge use the incoming codes so a zero-blank slot 0 is never a frame stale.
    frame_data  = frame_start ? bus.seg_in : shadow;
    drive       = (pre_cnt >= BLANK_V) && bus.digit_en[idx];
`ifdef SEG_DIM_EN
    k     = 32'(pre_cnt) - 32'(BLANK_CYC);
    win   = ((32'(bus.bright) + 32'd1) * 32'(SCAN_DIV - BLANK_CYC)) >> 2;
    drive = drive && (k < win);
`endif
    seg_nxt = 8'h00;
    dig_on  = '0;
    if (drive) begin
      seg_nxt     = frame_data[{idx, 3'b000} +: 8];
      dig_on[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      pre_cnt        <= '0;
      idx            <= '0;
      shadow         <= '0;
      bus.seg_com    <= 8'h00;
      bus.seg_dig    <= DIG_IDLE;
      bus.scan_idx   <= 3'd0;
      bus.frame_tick <= 1'b0;
    end else begin
      pre_cnt <= slot_end ? '0 : pre_cnt + CW'(1);
      if (slot_end) idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
      if (frame_start) shadow <= bus.seg_in;
      bus.seg_com    <= seg_nxt;
      bus.seg_dig    <= dig_on ^ DIG_IDLE;
      bus.scan_idx   <= 3'(idx);
      bus.frame_tick <= frame_end;
    end
  end
endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with N_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, active-low digit selects.
module tb_seg_scan_mux;
  logic clk;
  logic rst;
  int   ec;
  int   vectors;
  int   miscompares;

  seg_scan_mux_if #(.N_DIGITS(4)) bus ();

  seg_scan_mux #(
    .N_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .DIG_ACT_LOW(1'b1)
  ) dut (
    .clk_in(clk),
    .rst   (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          e;
    logic [31:0] seg_in;
    logic [3:0]  en;
    logic [7:0]  x_seg;
    logic [3:0]  x_dig;
    logic [2:0]  x_idx;
    logic        x_ft;
  } vec_t;

  vec_t tbl [22];

  task automatic tick();
    @(posedge clk);
    ec++;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @edge %0d: got %h expected %h", name, ec, got, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic [7:0] s, input logic [3:0] d,
                          input logic [2:0] i, input logic f);
    chk({name, ".seg_com"},    32'(bus.seg_com),    32'(s));
    chk({name, ".seg_dig"},    32'(bus.seg_dig),    32'(d));
    chk({name, ".scan_idx"},   32'(bus.scan_idx),   32'(i));
    chk({name, ".frame_tick"}, 32'(bus.frame_tick), 32'(f));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ec          = 0;
    tbl[0]  = '{1,  32'h4F5B063F, 4'hF, 8'h00, 4'hF, 3'd0, 1'b0};
    tbl[1]  = '{2,  32'h4F5B063F, 4'hF, 8'h00, 4'hF, 3'd0, 1'b0};
    tbl[2]  = '{3,  32'h4F5B063F, 4'hF, 8'h3F, 4'hE, 3'd0, 1'b0};
    tbl[3]  = '{8,  32'h4F5B063F, 4'hF, 8'h3F, 4'hE, 3'd0, 1'b0};
    tbl[4]  = '{9,  32'h4F5B063F, 4'hF, 8'h00, 4'hF, 3'd1, 1'b0};
    tbl[5]  = '{11, 32'h4F5B063F, 4'hF, 8'h06, 4'hD, 3'd1, 1'b0};
    tbl[6]  = '{12, 32'h4F5B066D, 4'hF, 8'h06, 4'hD, 3'd1, 1'b0};
    tbl[7]  = '{16, 32'h4F5B066D, 4'hF, 8'h06, 4'hD, 3'd1, 1'b0};
    tbl[8]  = '{19, 32'h4F5B066D, 4'hF, 8'h5B, 4'hB, 3'd2, 1'b0};
    tbl[9]  = '{27, 32'h4F5B066D, 4'hF, 8'h4F, 4'h7, 3'd3, 1'b0};
    tbl[10] = '{31, 32'h4F5B066D, 4'hF, 8'h4F, 4'h7, 3'd3, 1'b0};
    tbl[11] = '{32, 32'h4F5B066D, 4'hF, 8'h4F, 4'h7, 3'd3, 1'b1};
    tbl[12] = '{33, 32'h4F5B066D, 4'hF, 8'h00, 4'hF, 3'd0, 1'b0};
    tbl[13] = '{35, 32'h4F5B066D, 4'hF, 8'h6D, 4'hE, 3'd0, 1'b0};
    tbl[14] = '{40, 32'h4F5B066D, 4'hB, 8'h6D, 4'hE, 3'd0, 1'b0};
    tbl[15] = '{43, 32'h4F5B066D, 4'hB, 8'h06, 4'hD, 3'd1, 1'b0};
    tbl[16] = '{51, 32'h4F5B066D, 4'hB, 8'h00, 4'hF, 3'd2, 1'b0};
    tbl[17] = '{56, 32'h4F5B066D, 4'hB, 8'h00, 4'hF, 3'd2, 1'b0};
    tbl[18] = '{59, 32'h4F5B066D, 4'hB, 8'h4F, 4'h7, 3'd3, 1'b0};
    tbl[19] = '{63, 32'h4F5B066D, 4'hB, 8'h4F, 4'h7, 3'd3, 1'b0};
    tbl[20] = '{64, 32'h4F5B066D, 4'hB, 8'h4F, 4'h7, 3'd3, 1'b1};
    tbl[21] = '{65, 32'h4F5B066D, 4'hB, 8'h00, 4'hF, 3'd0, 1'b0};

    // Reset held for three edges with garbage codes on the input.
    rst          = 1'b1;
    bus.seg_in   = 32'hFFFFFFFF;
    bus.digit_en = 4'hF;
`ifdef SEG_DIM_EN
    bus.bright   = 2'd3;
`endif
    repeat (3) tick();
    chk_outs("reset", 8'h00, 4'hF, 3'd0, 1'b0);

    rst = 1'b0;
    ec  = 0;
    for (int i = 0; i < 22; i++) begin
      while (ec < tbl[i].e - 1) tick();
      bus.seg_in   = tbl[i].seg_in;
      bus.digit_en = tbl[i].en;
      tick();
      chk_outs($sformatf("vec%0d", i), tbl[i].x_seg, tbl[i].x_dig, tbl[i].x_idx, tbl[i].x_ft);
    end

    // Mid-slot reset while digit 2 is driving.
    bus.digit_en = 4'hF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ec  = 0;
    while (ec < 19) tick();
    chk_outs("pre_rst", 8'h5B, 4'hB, 3'd2, 1'b0);
    rst = 1'b1;
    tick();
    chk_outs("mid_rst", 8'h00, 4'hF, 3'd0, 1'b0);
    rst = 1'b0;
    ec  = 0;
    for (int e = 1; e <= 64; e++) begin
      tick();
      chk("frame_tick", 32'(bus.frame_tick), 32'((e % 32) == 0));
      chk("onehot", 32'($countones(~bus.seg_dig) <= 1), 32'd1);
      if (e <= 2) chk("post_rst_blank", 32'(bus.seg_dig), 32'hF);
      if (e >= 3 && e <= 8) chk_outs("post_rst_d0", 8'h6D, 4'hE, 3'd0, 1'b0);
    end

`ifdef SEG_DIM_EN
    begin
      logic [1:0] br [3];
      int         want [3];
      int         on_cnt;
      br[0] = 2'd0; want[0] = 1;
      br[1] = 2'd1; want[1] = 3;
      br[2] = 2'd3; want[2] = 6;
      for (int b = 0; b < 3; b++) begin
        bus.bright = br[b];
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ec  = 0;
        on_cnt = 0;
        for (int e = 1; e <= 8; e++) begin
          tick();
          if (bus.seg_dig != 4'hF) on_cnt++;
          if (e == 3) chk($sformatf("dim%0d_edge3", b), 32'(bus.seg_dig), 32'hE);
        end
        chk($sformatf("dim%0d_cycles", b), 32'(on_cnt), 32'(want[b]));
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
